multi_code_lock: RTL and testbench

- Parametrised successor to the two-button sequence lock. Accepts a CODE_LEN-digit code from NUM_BTN one-hot buttons and drives a timed unlock pulse.
- Adds failed-attempt counting with timed lockout, an inter-press entry timeout, and runtime re-programming of the code while unlocked.
- Sits between the debounced/edge-detected button front end and the actuator driver.

---
 rtl/multi_code_lock_pkg.sv | 30 +++
 rtl/multi_code_lock_timer.sv | 27 ++
 rtl/multi_code_lock.sv | 173 +++++++++++++++++
 tb/tb_multi_code_lock.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/multi_code_lock_pkg.sv
// Shared types and helpers for the multi-digit code lock.
// Digit index width and one-hot button decoding live here.
package multi_code_lock_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENTER,
      OPEN,
      PROG,
      LOCKOUT
   } lock_state_e;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic oh_valid(input logic [31:0] v);
      return (v != '0) && ((v & (v - 32'd1)) == '0);
   endfunction

   function automatic logic [4:0] oh_idx(input logic [31:0] v);
      logic [4:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) r = 5'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/multi_code_lock_timer.sv
// Loadable saturating down-counter; done while the count is zero.
// One instance serves unlock hold, lockout and entry timeout.
module multi_code_lock_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/multi_code_lock.sv
// Multi-digit button code lock with lockout, entry timeout
// and runtime re-programming of the code while open.
module multi_code_lock
   import multi_code_lock_pkg::*;
#(
   parameter int NUM_BTN        = 2,
   parameter int CODE_LEN       = 5,
   parameter logic [CODE_LEN*idx_w(NUM_BTN)-1:0]
                 DEFAULT_CODE   = 'h0B,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 1024,
   parameter int UNLOCK_CYCLES  = 16,
   parameter int ENTRY_TIMEOUT  = 256
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_BTN-1:0]             btn,
   input  logic                           prog_en,
   output logic                           unlock,
   output logic                           locked_out,
   output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
   output logic                           prog_done
);

   localparam int IDX_W = idx_w(NUM_BTN);
   localparam int CW    = idx_w(CODE_LEN);
   localparam int FW    = $clog2(MAX_FAILS + 1);
   localparam int KW    = CODE_LEN * IDX_W;
   localparam int TM0   = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ?
                          LOCKOUT_CYCLES : UNLOCK_CYCLES;
   localparam int TMAX  = (TM0 > ENTRY_TIMEOUT) ?
                          TM0 : ENTRY_TIMEOUT;
   localparam int TW    = $clog2(TMAX + 1);

   localparam logic [TW-1:0] T_OPEN = TW'(UNLOCK_CYCLES - 1);
   localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [TW-1:0] T_IDLE = TW'(ENTRY_TIMEOUT - 1);
   localparam logic [FW-1:0] F_MAX  = FW'(MAX_FAILS);
   localparam logic [CW-1:0] C_LAST = CW'(CODE_LEN - 1);

   lock_state_e state_q, state_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic             mm_q, mm_d;
   logic [FW-1:0]    fail_q, fail_d;
   logic [KW-1:0]    code_q, code_d;
   logic [KW-1:0]    shadow_q, shadow_d;
   logic             pdone_q, pdone_d;

   logic             tload;
   logic [TW-1:0]    tval;
   logic             tdone;

   logic             press, valid, last, miss, mm_tot;
   logic [IDX_W-1:0] digit, exp_dig;
   logic [CW-1:0]    cur;
   logic [FW-1:0]    fail_inc;

   multi_code_lock_timer #(.W(TW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (tload),
      .val_i  (tval),
      .done_o (tdone)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         mm_q     <= 1'b0;
         fail_q   <= '0;
         code_q   <= DEFAULT_CODE;
         shadow_q <= '0;
         pdone_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         mm_q     <= mm_d;
         fail_q   <= fail_d;
         code_q   <= code_d;
         shadow_q <= shadow_d;
         pdone_q  <= pdone_d;
      end
   end

   // Digit position restarts at 0 whenever a new sequence begins.
   assign cur      = (state_q == ENTER || state_q == PROG) ?
                     idx_q : '0;
   assign press    = |btn;
   assign valid    = oh_valid(32'(btn));
   assign digit    = IDX_W'(oh_idx(32'(btn)));
   assign exp_dig  = code_q[cur*IDX_W +: IDX_W];
   assign last     = (cur == C_LAST);
   assign miss     = !valid || (digit != exp_dig);
   assign mm_tot   = miss || (state_q == ENTER && mm_q);
   assign fail_inc = (fail_q == F_MAX) ? fail_q : fail_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      mm_d     = mm_q;
      fail_d   = fail_q;
      code_d   = code_q;
      shadow_d = shadow_q;
      pdone_d  = 1'b0;
      tload    = 1'b0;
      tval     = T_IDLE;
      unique case (state_q)
         IDLE, ENTER: begin
            if (press) begin
               if (!last) begin
                  state_d = ENTER;
                  idx_d   = cur + 1'b1;
                  mm_d    = mm_tot;
                  tload   = 1'b1;
                  tval    = T_IDLE;
               end else if (!mm_tot) begin
                  state_d = OPEN;
                  fail_d  = '0;
                  tload   = 1'b1;
                  tval    = T_OPEN;
               end else begin
                  fail_d  = fail_inc;
                  state_d = IDLE;
                  if (fail_inc == F_MAX) begin
                     state_d = LOCKOUT;
                     tload   = 1'b1;
                     tval    = T_LOCK;
                  end
               end
            end else if (state_q == ENTER && tdone) begin
               state_d = IDLE;
            end
         end
         OPEN, PROG: begin
            if (state_q == PROG && !prog_en) begin
               state_d = IDLE;
            end else if (prog_en && press) begin
               if (!valid) begin
                  state_d = IDLE;
               end else begin
                  shadow_d[cur*IDX_W +: IDX_W] = digit;
                  if (last) begin
                     code_d  = shadow_d;
                     pdone_d = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = PROG;
                     idx_d   = cur + 1'b1;
                     tload   = 1'b1;
                     tval    = T_IDLE;
                  end
               end
            end else if (tdone) begin
               state_d = IDLE;
            end
         end
         LOCKOUT: begin
            if (tdone) begin
               fail_d  = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign unlock     = (state_q == OPEN);
   assign locked_out = (state_q == LOCKOUT);
   assign fail_cnt   = fail_q;
   assign prog_done  = pdone_q;

endmodule

// File: tb/tb_multi_code_lock.sv
// Directed bench for multi_code_lock with default parameters.
// Codes are given as 5-bit vectors, digit 0 in bit 0.
module tb_multi_code_lock;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       prog_en = 1'b0;
   logic [1:0] btn = '0;
   logic       unlock, locked_out, prog_done;
   logic [1:0] fail_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   int un_cyc = 0;
   int lk_cyc = 0;
   int pd_cyc = 0;

   localparam logic [4:0] C_DEF = 5'b01011;
   localparam logic [4:0] C_BAD = 5'b01010;
   localparam logic [4:0] C_NEW = 5'b01100;

   multi_code_lock dut (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .prog_en    (prog_en),
      .unlock     (unlock),
      .locked_out (locked_out),
      .fail_cnt   (fail_cnt),
      .prog_done  (prog_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (unlock)     un_cyc++;
      if (locked_out) lk_cyc++;
      if (prog_done)  pd_cyc++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [1:0] b);
      btn = b;
      @(negedge clk);
      btn = '0;
   endtask

   task automatic enter(input logic [4:0] c);
      for (int i = 0; i < 5; i++)
         press(c[i] ? 2'b10 : 2'b01);
   endtask

   task automatic wait_closed();
      int n;
      n = 0;
      while (unlock && n < 100) begin
         tick();
         n++;
      end
      chk("open_bound", unlock, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      tick(2);
      chk("rst_unlock", unlock, 0);
      chk("rst_locked", locked_out, 0);
      chk("rst_fail", fail_cnt, 0);
      chk("rst_pdone", prog_done, 0);
      rst = 1'b1;
      tick();

      un_cyc = 0;
      enter(C_DEF);
      chk("open_rise", unlock, 1);
      chk("open_fail", fail_cnt, 0);
      wait_closed();
      chk("open_len", un_cyc, 16);

      enter(C_BAD);
      chk("fail1", fail_cnt, 1);
      chk("fail1_unl", unlock, 0);
      enter(C_BAD);
      chk("fail2", fail_cnt, 2);
      chk("fail2_lock", locked_out, 0);
      lk_cyc = 0;
      enter(C_BAD);
      chk("lock_rise", locked_out, 1);
      chk("fail3", fail_cnt, 3);
      enter(C_DEF);
      chk("lock_ign", unlock, 0);
      chk("lock_hold", locked_out, 1);
      n = 0;
      while (locked_out && n < 2000) begin
         tick();
         n++;
      end
      chk("lock_len", lk_cyc, 1024);
      chk("lock_clr", fail_cnt, 0);
      enter(C_DEF);
      chk("post_lock", unlock, 1);
      wait_closed();

      press(2'b10);
      press(2'b10);
      tick(255);
      press(2'b01);
      press(2'b10);
      press(2'b01);
      chk("to_255", unlock, 1);
      wait_closed();

      press(2'b10);
      press(2'b10);
      tick(256);
      chk("to_fail", fail_cnt, 0);
      enter(C_DEF);
      chk("to_open", unlock, 1);
      wait_closed();

      enter(C_DEF);
      prog_en = 1'b1;
      pd_cyc = 0;
      enter(C_NEW);
      chk("pg_done", prog_done, 1);
      chk("pg_unl", unlock, 0);
      prog_en = 1'b0;
      tick();
      chk("pg_once", pd_cyc, 1);
      enter(C_DEF);
      chk("pg_old", fail_cnt, 1);
      chk("pg_old_unl", unlock, 0);
      enter(C_NEW);
      chk("pg_new", unlock, 1);
      chk("pg_new_f", fail_cnt, 0);
      wait_closed();

      enter(C_NEW);
      prog_en = 1'b1;
      pd_cyc = 0;
      press(2'b10);
      press(2'b10);
      prog_en = 1'b0;
      tick(2);
      chk("ab_pd", pd_cyc, 0);
      chk("ab_unl", unlock, 0);
      enter(C_NEW);
      chk("ab_keep", unlock, 1);
      wait_closed();

      press(2'b01);
      press(2'b01);
      press(2'b11);
      press(2'b10);
      press(2'b01);
      chk("inv_fail", fail_cnt, 1);
      chk("inv_unl", unlock, 0);

      press(2'b10);
      press(2'b10);
      #2 rst = 1'b0;
      #1;
      chk("ar_fail", fail_cnt, 0);
      chk("ar_unl", unlock, 0);
      chk("ar_lock", locked_out, 0);
      chk("ar_pd", prog_done, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      enter(C_DEF);
      chk("ar_def", unlock, 1);
      wait_closed();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
